id_stage_pipe: RTL and testbench

- Parametrised next-generation decode stage for the pipelined MIPS core.
- Contains the register file (NREG x XLEN) and the HI/LO registers, with write-through bypass on all reads.
- Drives a registered ID/EX pipeline boundary with stall, flush and bubble insertion.
- Detects load-use hazards against the instruction it issued last cycle and stalls fetch for exactly one cycle.

---
 rtl/id_stage_pipe_if.sv | 57 +++++
 rtl/id_stage_pipe.sv | 136 +++++++++++++
 tb/tb_id_stage_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : id_stage_pipe_if
// Brief  : Decode-stage bundle: ID inputs, writeback ports, ID/EX outputs.
// Rev    : 1.0  initial release
// ============================================================================
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [31:0]     ir;
    logic            ir_valid;
    logic            syscall;
    logic            unsigned_ext_imm;
    logic            reg_dst;
    logic            jr;
    logic            jal;
    logic            branch;
    logic            mem_read;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_in;
    logic [XLEN-1:0] lo_in;
    logic            stall;
    logic            bubble;
    logic            ex_valid;
    logic            ex_mem_read;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_shamt;
    logic [AW-1:0]   ex_wb_reg;
    logic [XLEN-1:0] ex_jaddr;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport slave (
        input  ir, ir_valid, syscall, unsigned_ext_imm, reg_dst, jr, jal, branch,
               mem_read, flush, wb_we, wb_reg, wb_data, hi_we, lo_we, hi_in, lo_in,
        output stall, bubble, ex_valid, ex_mem_read, ex_rd1, ex_rd2, ex_imm,
               ex_shamt, ex_wb_reg, ex_jaddr, hi, lo
    );

    modport master (
        output ir, ir_valid, syscall, unsigned_ext_imm, reg_dst, jr, jal, branch,
               mem_read, flush, wb_we, wb_reg, wb_data, hi_we, lo_we, hi_in, lo_in,
        input  stall, bubble, ex_valid, ex_mem_read, ex_rd1, ex_rd2, ex_imm,
               ex_shamt, ex_wb_reg, ex_jaddr, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module : id_stage_pipe
// Brief  : MIPS decode stage with bypassed register file, HI/LO, ID/EX register
//          and one-cycle load-use stall.
// Rev    : 1.0  initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int SYS_R1   = 4,
    parameter int SYS_R2   = 2,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               rst,
    id_stage_pipe_if.slave     bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_rf [NREG];
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            r_ex_valid;
    logic            r_ex_mem_read;
    logic [XLEN-1:0] r_ex_rd1;
    logic [XLEN-1:0] r_ex_rd2;
    logic [XLEN-1:0] r_ex_imm;
    logic [4:0]      r_ex_shamt;
    logic [AW-1:0]   r_ex_wb_reg;
    logic [XLEN-1:0] r_ex_jaddr;

    logic            w_wb_en;
    logic [AW-1:0]   w_r1;
    logic [AW-1:0]   w_r2;
    logic [AW-1:0]   w_dst;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_jaddr;
    logic            w_hazard;
    logic            w_stall;
    logic            w_unused_opcode;

    assign w_unused_opcode = ^bus.ir[31:26];

    assign w_wb_en = bus.wb_we && (bus.wb_reg != '0);
    assign w_r1    = bus.syscall ? AW'(SYS_R1) : AW'(bus.ir[25:21]);
    assign w_r2    = bus.syscall ? AW'(SYS_R2) : AW'(bus.ir[20:16]);
    assign w_dst   = bus.jal     ? AW'(LINK_REG)
                   : (bus.reg_dst ? AW'(bus.ir[15:11]) : AW'(bus.ir[20:16]));

    // Same-cycle writeback is forwarded so a write and a dependent read may coincide.
    always_comb begin
        w_rd1 = r_rf[w_r1];
        w_rd2 = r_rf[w_r2];
        if (w_wb_en && bus.wb_reg == w_r1) w_rd1 = bus.wb_data;
        if (w_wb_en && bus.wb_reg == w_r2) w_rd2 = bus.wb_data;
        if (w_r1 == '0) w_rd1 = '0;
        if (w_r2 == '0) w_rd2 = '0;
    end

    assign w_imm   = bus.unsigned_ext_imm ? {{(XLEN-16){1'b0}}, bus.ir[15:0]}
                                          : {{(XLEN-16){bus.ir[15]}}, bus.ir[15:0]};
    assign w_jaddr = bus.jr ? w_rd1 : {{(XLEN-26){1'b0}}, bus.ir[25:0]};

    // jal does not read rt, so a match on r2 is ignored for it.
    assign w_hazard = bus.ir_valid && r_ex_valid && r_ex_mem_read &&
                      (r_ex_wb_reg != '0) &&
                      ((r_ex_wb_reg == w_r1) || ((r_ex_wb_reg == w_r2) && !bus.jal));
    assign w_stall  = w_hazard && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_wb_en) begin
            r_rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (bus.hi_we) r_hi <= bus.hi_in;
            if (bus.lo_we) r_lo <= bus.lo_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_rd1      <= '0;
            r_ex_rd2      <= '0;
            r_ex_imm      <= '0;
            r_ex_shamt    <= '0;
            r_ex_wb_reg   <= '0;
            r_ex_jaddr    <= '0;
        end else if (bus.flush || w_stall) begin
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_rd1      <= '0;
            r_ex_rd2      <= '0;
            r_ex_imm      <= '0;
            r_ex_shamt    <= '0;
            r_ex_wb_reg   <= '0;
            r_ex_jaddr    <= '0;
        end else begin
            r_ex_valid    <= bus.ir_valid;
            r_ex_mem_read <= bus.mem_read && bus.ir_valid;
            r_ex_rd1      <= w_rd1;
            r_ex_rd2      <= w_rd2;
            r_ex_imm      <= w_imm;
            r_ex_shamt    <= bus.ir[10:6];
            r_ex_wb_reg   <= w_dst;
            r_ex_jaddr    <= w_jaddr;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.bubble      = bus.ir_valid && bus.branch;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_mem_read = r_ex_mem_read;
    assign bus.ex_rd1      = r_ex_rd1;
    assign bus.ex_rd2      = r_ex_rd2;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_shamt    = r_ex_shamt;
    assign bus.ex_wb_reg   = r_ex_wb_reg;
    assign bus.ex_jaddr    = r_ex_jaddr;
    assign bus.hi          = bus.hi_we ? bus.hi_in : r_hi;
    assign bus.lo          = bus.lo_we ? bus.lo_in : r_lo;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_id_stage_pipe
// Brief  : Directed table-driven bench for id_stage_pipe (32-bit and 64-bit).
// Rev    : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .NREG(32)) b32 ();
    id_stage_pipe_if #(.XLEN(64), .NREG(16)) b64 ();

    id_stage_pipe #(.XLEN(32), .NREG(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    id_stage_pipe #(.XLEN(64), .NREG(16)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ir;
        logic        sys, uext, rdst, jr, jal, mr, v;
        logic [31:0] e_rd1, e_rd2, e_imm, e_jaddr;
        logic [4:0]  e_wb;
        logic        e_v, e_mr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        b32.ir = '0; b32.ir_valid = 0; b32.syscall = 0; b32.unsigned_ext_imm = 0;
        b32.reg_dst = 0; b32.jr = 0; b32.jal = 0; b32.branch = 0; b32.mem_read = 0;
        b32.flush = 0; b32.wb_we = 0; b32.wb_reg = '0; b32.wb_data = '0;
        b32.hi_we = 0; b32.lo_we = 0; b32.hi_in = '0; b32.lo_in = '0;
    endtask

    task automatic issue_lw9();
        idle32();
        b32.ir = {6'h23, 5'd1, 5'd9, 16'h0000};
        b32.ir_valid = 1; b32.mem_read = 1;
        tick();
        idle32();
    endtask

    initial begin
        idle32();
        b64.ir = '0; b64.ir_valid = 0; b64.syscall = 0; b64.unsigned_ext_imm = 0;
        b64.reg_dst = 0; b64.jr = 0; b64.jal = 0; b64.branch = 0; b64.mem_read = 0;
        b64.flush = 0; b64.wb_we = 0; b64.wb_reg = '0; b64.wb_data = '0;
        b64.hi_we = 0; b64.lo_we = 0; b64.hi_in = '0; b64.lo_in = '0;

        //           ir                                  sys uext rdst jr jal mr v  rd1       rd2       imm           jaddr         wb  ev emr
        tbl[0] = '{{6'h00, 5'd1, 5'd2, 16'h1800},     0, 0, 1, 0, 0, 0, 1, 32'h101, 32'h102, 32'h00001800, 32'h00221800, 5'd3,  1, 0};
        tbl[1] = '{{6'h23, 5'd5, 5'd7, 16'h8000},     0, 0, 0, 0, 0, 0, 1, 32'h105, 32'h107, 32'hFFFF8000, 32'h00A78000, 5'd7,  1, 0};
        tbl[2] = '{{6'h23, 5'd5, 5'd7, 16'h8000},     0, 1, 0, 0, 0, 0, 1, 32'h105, 32'h107, 32'h00008000, 32'h00A78000, 5'd7,  1, 0};
        tbl[3] = '{{6'h03, 26'h0123456},              0, 0, 0, 0, 1, 0, 1, 32'h0,   32'h112, 32'h00003456, 32'h00123456, 5'd31, 1, 0};
        tbl[4] = '{{6'h00, 5'd9, 5'd0, 16'h0008},     0, 0, 0, 1, 0, 0, 1, 32'h109, 32'h0,   32'h00000008, 32'h00000109, 5'd0,  1, 0};
        tbl[5] = '{{6'h00, 5'd20, 5'd21, 16'hFFFF},   1, 0, 0, 0, 0, 0, 1, 32'h104, 32'h102, 32'hFFFFFFFF, 32'h0295FFFF, 5'd21, 1, 0};
        tbl[6] = '{{6'h00, 5'd1, 5'd2, 16'h1800},     0, 0, 1, 0, 0, 1, 0, 32'h101, 32'h102, 32'h00001800, 32'h00221800, 5'd3,  0, 0};
        tbl[7] = '{{6'h00, 5'd1, 5'd2, 16'h1800},     0, 0, 1, 0, 0, 1, 1, 32'h101, 32'h102, 32'h00001800, 32'h00221800, 5'd3,  1, 1};

        // Reset state, sampled while reset is still held
        #2;
        chk("rst_ex_valid", 64'(b32.ex_valid), 64'd0);
        chk("rst_hi", 64'(b32.hi), 64'd0);
        chk("rst_stall", 64'(b32.stall), 64'd0);
        #5 rst = 0;
        #5;

        // Preload rf[k] = 0x100 + k
        for (int k = 1; k < 32; k++) begin
            b32.wb_we = 1; b32.wb_reg = 5'(k); b32.wb_data = 32'h100 + 32'(k);
            tick();
        end
        idle32();

        for (int i = 0; i < 8; i++) begin
            b32.ir = tbl[i].ir; b32.syscall = tbl[i].sys; b32.unsigned_ext_imm = tbl[i].uext;
            b32.reg_dst = tbl[i].rdst; b32.jr = tbl[i].jr; b32.jal = tbl[i].jal;
            b32.mem_read = tbl[i].mr; b32.ir_valid = tbl[i].v;
            tick();
            chk($sformatf("v%0d_rd1", i),   64'(b32.ex_rd1),      64'(tbl[i].e_rd1));
            chk($sformatf("v%0d_rd2", i),   64'(b32.ex_rd2),      64'(tbl[i].e_rd2));
            chk($sformatf("v%0d_imm", i),   64'(b32.ex_imm),      64'(tbl[i].e_imm));
            chk($sformatf("v%0d_jaddr", i), 64'(b32.ex_jaddr),    64'(tbl[i].e_jaddr));
            chk($sformatf("v%0d_wb", i),    64'(b32.ex_wb_reg),   64'(tbl[i].e_wb));
            chk($sformatf("v%0d_valid", i), 64'(b32.ex_valid),    64'(tbl[i].e_v));
            chk($sformatf("v%0d_mr", i),    64'(b32.ex_mem_read), 64'(tbl[i].e_mr));
        end
        chk("v0_shamt_src", 64'(b32.ex_shamt), 64'd0);
        idle32();
        tick();

        // Write bypass, then r0 immunity
        b32.wb_we = 1; b32.wb_reg = 5'd8; b32.wb_data = 32'hDEADBEEF;
        b32.ir = {6'h00, 5'd8, 5'd0, 5'd0, 5'd17, 6'h00}; b32.ir_valid = 1;
        tick();
        chk("byp_rd1", 64'(b32.ex_rd1), 64'hDEADBEEF);
        chk("byp_shamt", 64'(b32.ex_shamt), 64'd17);
        b32.wb_reg = 5'd0; b32.wb_data = 32'h1234;
        b32.ir = {6'h00, 5'd0, 5'd0, 16'h0000};
        tick();
        chk("r0_rd1", 64'(b32.ex_rd1), 64'd0);
        chk("r0_rd2", 64'(b32.ex_rd2), 64'd0);
        idle32();
        tick();

        // Load-use: exactly one stall cycle
        issue_lw9();
        b32.ir = {6'h00, 5'd9, 5'd3, 5'd4, 11'h020}; b32.reg_dst = 1; b32.ir_valid = 1;
        #1;
        chk("lu_stall", 64'(b32.stall), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(b32.ex_valid), 64'd0);
        chk("lu_stall_drop", 64'(b32.stall), 64'd0);
        tick();
        chk("lu_issue_valid", 64'(b32.ex_valid), 64'd1);
        chk("lu_issue_wb", 64'(b32.ex_wb_reg), 64'd4);
        chk("lu_issue_rd1", 64'(b32.ex_rd1), 64'h109);
        idle32();
        tick();

        // Independent consumer: no stall
        issue_lw9();
        b32.ir = {6'h00, 5'd10, 5'd3, 5'd4, 11'h020}; b32.reg_dst = 1; b32.ir_valid = 1;
        #1;
        chk("nolu_stall", 64'(b32.stall), 64'd0);
        tick();
        chk("nolu_valid", 64'(b32.ex_valid), 64'd1);
        idle32();
        tick();

        // jal ignores rt match
        issue_lw9();
        b32.ir = {6'h03, 5'd0, 5'd9, 16'h0000}; b32.jal = 1; b32.ir_valid = 1;
        #1;
        chk("jal_rt_stall", 64'(b32.stall), 64'd0);
        idle32();
        tick();

        // Flush overrides hazard
        issue_lw9();
        b32.ir = {6'h00, 5'd9, 5'd3, 5'd4, 11'h020}; b32.ir_valid = 1; b32.flush = 1;
        #1;
        chk("fl_stall", 64'(b32.stall), 64'd0);
        tick();
        chk("fl_valid", 64'(b32.ex_valid), 64'd0);
        idle32();

        // Bubble output
        b32.ir_valid = 1; b32.branch = 1;
        #1;
        chk("bubble_on", 64'(b32.bubble), 64'd1);
        b32.ir_valid = 0;
        #1;
        chk("bubble_off", 64'(b32.bubble), 64'd0);
        idle32();
        tick();

        // HI/LO bypass and retention
        b32.hi_we = 1; b32.hi_in = 32'h55; b32.lo_we = 1; b32.lo_in = 32'hAA;
        #1;
        chk("hi_byp", 64'(b32.hi), 64'h55);
        chk("lo_byp", 64'(b32.lo), 64'hAA);
        tick();
        b32.hi_we = 0; b32.lo_we = 0; b32.hi_in = 32'h77;
        #1;
        chk("hi_keep", 64'(b32.hi), 64'h55);
        chk("lo_keep", 64'(b32.lo), 64'hAA);
        tick();

        // Async reset during a stall
        issue_lw9();
        b32.ir = {6'h00, 5'd9, 5'd3, 5'd4, 11'h020}; b32.ir_valid = 1;
        #1;
        chk("mid_stall_pre", 64'(b32.stall), 64'd1);
        #2 rst = 1;
        #1;
        chk("mid_stall", 64'(b32.stall), 64'd0);
        chk("mid_ex_valid", 64'(b32.ex_valid), 64'd0);
        chk("mid_ex_mr", 64'(b32.ex_mem_read), 64'd0);
        chk("mid_ex_wb", 64'(b32.ex_wb_reg), 64'd0);
        chk("mid_hi", 64'(b32.hi), 64'd0);
        chk("mid_lo", 64'(b32.lo), 64'd0);
        #1 rst = 0;
        tick();
        chk("post_rst_rf", 64'(b32.ex_rd1), 64'd0);
        chk("post_rst_valid", 64'(b32.ex_valid), 64'd1);
        idle32();

        // 64-bit / 16-register instance
        b64.wb_we = 1; b64.wb_reg = 4'd15; b64.wb_data = 64'h1122334455667788;
        b64.ir = {6'h00, 5'd15, 5'd13, 16'h8000}; b64.ir_valid = 1;
        tick();
        chk("w64_byp_rd1", b64.ex_rd1, 64'h1122334455667788);
        chk("w64_imm", b64.ex_imm, 64'hFFFFFFFFFFFF8000);
        chk("w64_wb", 64'(b64.ex_wb_reg), 64'd13);
        chk("w64_jaddr", b64.ex_jaddr, 64'h0000000001ED8000);
        b64.wb_we = 0;
        tick();
        chk("w64_rf_rd1", b64.ex_rd1, 64'h1122334455667788);
        b64.ir_valid = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
